// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and helpers for the programmable clock divider
//
// Contents:
//   clkdiv_mode_t  per-channel output mode (toggle clock or tick strobe)
//   CNT_WIDTH_DEF  default divisor/counter width
//   div_t          divisor type at the default width
//   ch_width()     width of a channel-select field for n channels (at least 1)
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } clkdiv_mode_t;

  localparam int CNT_WIDTH_DEF = 24;

  typedef logic [CNT_WIDTH_DEF-1:0] div_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel: counter, active/shadow divisor, registered outputs
//
// Ports:
//   clk_in    system clock, rising edge
//   reset     asynchronous active-high reset
//   enable    channel run enable; low holds counter and outputs at 0
//   mode      MODE_TOGGLE: clk_out flips at each terminal; MODE_TICK: clk_out mirrors tick
//   restart   phase-align: zero the counter without applying a pending divisor
//   wr_en     accepted divisor write addressed to this channel
//   wr_value  new divisor (already checked non-zero by the top level)
//   clk_out   divided clock or tick copy
//   tick      one-cycle strobe at each terminal count
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = 1666666
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  clkdiv_mode_t         mode,
  input  logic                 restart,
  input  logic                 wr_en,
  input  logic [CNT_WIDTH-1:0] wr_value,
  output logic                 clk_out,
  output logic                 tick
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] active_div;
  logic [CNT_WIDTH-1:0] shadow_div;
  logic                 pending;
  logic                 terminal;
  logic                 apply;

  assign terminal = enable && (counter == active_div - ONE);

  // A stopped channel picks up a new divisor immediately; a running one only
  // at a terminal so the period in flight is never cut short. Restart wins
  // over terminal, so a pending divisor survives a restart.
  assign apply = pending && (!enable || (!restart && terminal));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      active_div <= DIV_RST;
      shadow_div <= DIV_RST;
      pending    <= 1'b0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_div <= wr_value;
      end

      // The pending flag is registered, so a write landing on a terminal
      // cycle is not seen until the following terminal.
      if (wr_en) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (apply) begin
        active_div <= shadow_div;
      end

      if (!enable) begin
        counter <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (restart) begin
        counter <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (terminal) begin
        counter <= '0;
        tick    <= 1'b1;
        clk_out <= (mode == MODE_TICK) ? 1'b1 : ~clk_out;
      end else begin
        counter <= counter + ONE;
        tick    <= 1'b0;
        clk_out <= (mode == MODE_TICK) ? 1'b0 : clk_out;
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable clock/tick generator
//
// Ports:
//   clk_in     system clock, rising edge
//   reset      asynchronous active-high reset
//   enable     per-channel run enable
//   mode       per-channel mode: 0 = toggle clock, 1 = tick copy
//   restart    zero the counters of all enabled channels
//   div_wr     one-cycle divisor write strobe
//   div_ch     channel addressed by the write
//   div_value  new divisor
//   div_err    one-cycle pulse the cycle after a rejected write
//   clk_out    per-channel divided clock / tick copy
//   tick       per-channel terminal-count strobe
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = 1666666
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enable,
  input  logic [NUM_CH-1:0]           mode,
  input  logic                        restart,
  input  logic                        div_wr,
  input  logic [ch_width(NUM_CH)-1:0] div_ch,
  input  logic [CNT_WIDTH-1:0]        div_value,
  output logic                        div_err,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick
);

  localparam int              CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic write_bad;

  // One extra bit so the range check still works when NUM_CH is a power of two.
  assign write_bad = (div_value == '0) || ({1'b0, div_ch} >= NUM_CH_V);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_err <= 1'b0;
    end else begin
      div_err <= div_wr && write_bad;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;

    assign wr_sel = div_wr && !write_bad && (div_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk_in   (clk_in),
      .reset    (reset),
      .enable   (enable[i]),
      .mode     (clkdiv_mode_t'(mode[i])),
      .restart  (restart),
      .wr_en    (wr_sel),
      .wr_value (div_value),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Multi-channel programmable clock/tick generator that replaces fixed-divisor single-output dividers. It is clocked by the board clock clk_in. Each channel divides clk_in by a runtime-loadable divisor and produces either a 50%-style toggled clock or a one-cycle tick strobe. Typical consumers are display multiplexing, debouncers and UART baud timing.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_WIDTH, 24, width of divisor and per-channel counter
DEFAULT_DIV, 1666666, divisor loaded into every channel at reset; must be 1..2^CNT_WIDTH-1

Ports:
clk_in  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  NUM_CH  per-channel run enable
mode  input  NUM_CH  per-channel output mode; 0 = toggle, 1 = tick
restart  input  1  synchronous phase-align; zeroes every enabled channel's counter
div_wr  input  1  one-cycle divisor write strobe
div_ch  input  max(1,$clog2(NUM_CH))  target channel of the write
div_value  input  CNT_WIDTH  new divisor
div_err  output  1  one-cycle pulse, write rejected
clk_out  output  NUM_CH  divided clock (toggle mode) or copy of tick (tick mode)
tick  output  NUM_CH  one-cycle strobe at each terminal count

Behaviour:
- Reset (async, any time, including mid-period or with a write pending):
  - counters = 0, clk_out = 0, tick = 0, div_err = 0.
  - active_div = shadow_div = DEFAULT_DIV; pending = 0.
- Per-channel terminal condition: enable=1 and counter == active_div-1.
- At terminal:
  - counter <= 0 and tick <= 1 for one cycle; all outputs are registered.
  - Toggle mode: clk_out inverts, giving a period of 2*active_div cycles.
  - Tick mode: clk_out equals the registered tick.
- Otherwise counter increments and tick <= 0.
- div=1:
  - tick stays high continuously.
  - Toggle mode gives clk_out = clk_in/2.
- Divisor write (div_wr=1):
  - If div_value == 0 or div_ch >= NUM_CH: write ignored, div_err = 1 on the next cycle.
  - Otherwise shadow_div[div_ch] <= div_value and pending <= 1.
  - Back-to-back writes to the same channel: last one wins.
- Shadow application:
  - Enabled channel: active_div <= shadow_div at the first terminal strictly after the write cycle. A write in the same cycle as a terminal is applied at the following terminal. This gives glitch-free period changes.
  - Disabled channel: applied on the next cycle.
- enable=0:
  - counter held at 0, tick = 0, clk_out = 0 (both modes) from the next edge.
- enable rising:
  - Counting starts from 0.
  - First terminal occurs active_div cycles after the first enabled edge, i.e. tick high on edge active_div.
- restart=1:
  - All enabled channels: counter <= 0, tick <= 0.
  - clk_out <= 0 in toggle mode.
  - Pending shadows are not applied.
- Priority per channel: reset > enable=0 > restart > terminal > increment.
- Mode change mid-period takes effect on the next cycle. Switching tick->toggle starts clk_out from its current value (0 unless on a tick).
- Counter never exceeds active_div-1.
- A smaller divisor only becomes active at a terminal, which resets the counter, so no wrap-around past the terminal is possible.

Decomposition:
- Package clkdiv_pkg:
  - typedef enum logic {MODE_TOGGLE=1'b0, MODE_TICK=1'b1} clkdiv_mode_t
  - localparam CNT_WIDTH default
  - typedef logic [CNT_WIDTH-1:0] div_t
- Sub-module clkdiv_channel:
  - One counter, active/shadow divisor, pending flag, output registers.
  - Instantiated NUM_CH times with a generate loop.
- Top level: write decode, div_err generation and restart fan-out.

Test Plan:
- Bench uses DEFAULT_DIV=4, NUM_CH=4.
- Reset, enable[0]=1, mode=toggle -> clk_out[0] period 8 cycles, tick[0] every 4th cycle starting at cycle 4.
- Write ch1 div=2 mid-period (counter=1 of 4) -> current period completes at 4, then ticks every 2 cycles, no short pulse.
- div_value=0, then div_ch=5 with NUM_CH=4 -> div_err pulses 1 cycle each, divisors unchanged.
- div=1 on ch2, tick mode -> tick[2]=clk_out[2]=1 continuously; toggle mode -> clk_out[2] alternates every cycle.
- Channels 0 and 3 running out of phase, pulse restart -> both tick simultaneously 4 cycles later.
- Assert reset asynchronously between clock edges with pending write -> outputs 0 immediately, divisor back to 4, pending cleared.
